// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared definitions for the matrix-multiplier sequencing controller:
// state encoding, default geometry and the packed-element offset helper.
package matmul_pkg;

  localparam int MM_N  = 2;
  localparam int MM_DW = 8;

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  typedef enum logic [1:0] {
    LOAD_A = ST_LOAD_A,
    LOAD_B = ST_LOAD_B,
    WAIT   = ST_WAIT,
    DRAIN  = ST_DRAIN
  } state_e;

  // Bit offset of element (i,j) inside an N*N*DW packed operand bus.
  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j,
                                           input int unsigned n, input int unsigned dw);
    return (i * n + j) * dw;
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl.sv
// Streams A then B into packed buses for an external combinational multiplier,
// waits COMP_LAT cycles, captures the product and streams it back out.
// Optional job/stall counters are enabled by defining MATMUL_SEQ_CTRL_PERF_EN.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int N        = MM_N,
  parameter int DW       = MM_DW,
  parameter int COMP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic [N*N*DW-1:0] mm_a,
  output logic [N*N*DW-1:0] mm_b,
  input  logic [N*N*DW-1:0] mm_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              busy,
`ifdef MATMUL_SEQ_CTRL_PERF_EN
  output logic              done,
  output logic [15:0]       job_cnt,
  output logic [15:0]       stall_cnt
`else
  output logic              done
`endif
);

  localparam int NE   = N * N;
  localparam int BW   = NE * DW;
  localparam int IDXW = (NE > 1) ? $clog2(NE) : 1;
  localparam int WCW  = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NE - 1);
  localparam logic [WCW-1:0]  WC_LAST  = WCW'(COMP_LAT - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [BW-1:0]   mm_a_q, mm_a_d;
  logic [BW-1:0]   mm_b_q, mm_b_d;
  logic [BW-1:0]   res_q, res_d;
  logic [DW-1:0]   out_data_q, out_data_d;

  logic in_fire;
  logic out_fire;
  logic last_idx;

  assign in_ready  = rst_n && ((state_q == LOAD_A) || (state_q == LOAD_B));
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == WAIT) || (state_q == DRAIN);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_idx  = (idx_q == IDX_LAST);
  // Pulses in the same cycle the final result element is handed over.
  assign done      = out_fire && last_idx;

  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign out_data = out_data_q;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through this block infers a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    res_d      = res_q;
    out_data_d = out_data_q;

    case (state_q)
      LOAD_A: begin
        if (in_fire) begin
          mm_a_d[idx_q*DW +: DW] = in_data;
          if (last_idx) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      LOAD_B: begin
        if (in_fire) begin
          mm_b_d[idx_q*DW +: DW] = in_data;
          if (last_idx) begin
            idx_d   = '0;
            wcnt_d  = '0;
            state_d = WAIT;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      WAIT: begin
        if (wcnt_q == WC_LAST) begin
          // The first element is preloaded so out_data is valid on the first DRAIN cycle.
          res_d      = mm_res;
          out_data_d = mm_res[DW-1:0];
          idx_d      = '0;
          wcnt_d     = '0;
          state_d    = DRAIN;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            idx_d      = idx_q + IDXW'(1);
            out_data_d = res_q[idx_d*DW +: DW];
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= LOAD_A;
      idx_q      <= '0;
      wcnt_q     <= '0;
      // NOTE: the wide operand/result registers are cleared so a reset mid-job leaves no stale data.
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      res_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      res_q      <= res_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef MATMUL_SEQ_CTRL_PERF_EN
  logic [15:0] job_cnt_q;
  logic [15:0] stall_cnt_q;

  // job_cnt wraps naturally; stall_cnt holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      job_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (done) job_cnt_q <= job_cnt_q + 16'd1;
      if ((state_q == DRAIN) && !out_ready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign job_cnt   = job_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: behavioural multiplier and job-level model with a
// per-cycle compare process, plus directed jobs with hand-computed results.
module tb_matmul_seq_ctrl;
  import matmul_pkg::*;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int NE = N * N;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT (COMP_LAT=1)
  logic          in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [7:0]    in_data, out_data;
  logic [31:0]   mm_a, mm_b, mm_res;
  // Latency DUT (COMP_LAT=3)
  logic          l3_in_valid, l3_in_ready, l3_out_valid, l3_out_ready, l3_busy, l3_done;
  logic [7:0]    l3_in_data, l3_out_data;
  logic [31:0]   l3_mm_a, l3_mm_b, l3_mm_res;
`ifdef MATMUL_SEQ_CTRL_PERF_EN
  logic [15:0]   job_cnt, stall_cnt, l3_job_cnt, l3_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int stall_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural stand-in for the external multiplier: element sums mod 2^8.
  function automatic logic [31:0] mat_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [7:0]  s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++)
          s += a[elem_lsb(i, k, N, DW) +: 8] * b[elem_lsb(k, j, N, DW) +: 8];
        r[elem_lsb(i, j, N, DW) +: 8] = s;
      end
    return r;
  endfunction

  assign mm_res    = mat_mul(mm_a, mm_b);
  assign l3_mm_res = mat_mul(l3_mm_a, l3_mm_b);

  matmul_seq_ctrl #(.N(N), .DW(DW), .COMP_LAT(LAT1)) dut (
`ifdef MATMUL_SEQ_CTRL_PERF_EN
    .job_cnt(job_cnt), .stall_cnt(stall_cnt),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mm_a(mm_a), .mm_b(mm_b), .mm_res(mm_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done));

  matmul_seq_ctrl #(.N(N), .DW(DW), .COMP_LAT(LAT3)) dut_l3 (
`ifdef MATMUL_SEQ_CTRL_PERF_EN
    .job_cnt(l3_job_cnt), .stall_cnt(l3_stall_cnt),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(l3_in_valid), .in_ready(l3_in_ready),
    .in_data(l3_in_data), .mm_a(l3_mm_a), .mm_b(l3_mm_b), .mm_res(l3_mm_res),
    .out_valid(l3_out_valid), .out_ready(l3_out_ready), .out_data(l3_out_data),
    .busy(l3_busy), .done(l3_done));

  // ---------------- job-level model of the main DUT ----------------
  logic [7:0] acc[$];
  logic [7:0] exp_q[$];
  int         lat;

  function automatic logic [31:0] pack4(input int base);
    logic [31:0] r;
    for (int i = 0; i < NE; i++) r[i*8 +: 8] = acc[base+i];
    return r;
  endfunction

  always @(negedge clk) begin
    logic exp_valid;
    logic [31:0] c;
    if (!rst_n) begin
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      acc.delete();
      exp_q.delete();
      lat = 0;
    end else begin
      if (exp_q.size() != 0) lat++;
      exp_valid = (exp_q.size() != 0) && (lat >= LAT1 + 1);
      check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() == 0});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("done", {31'd0, done}, {31'd0, exp_valid && out_ready && exp_q.size() == 1});
      if (exp_valid) check("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
      if (exp_q.size() != 0 && acc.size() == 2*NE) begin
        check("mm_a_hold", mm_a, pack4(0));
        check("mm_b_hold", mm_b, pack4(NE));
      end
      if (in_valid && in_ready) begin
        acc.push_back(in_data);
        if (acc.size() == 2*NE) begin
          c = mat_mul(pack4(0), pack4(NE));
          for (int i = 0; i < NE; i++) exp_q.push_back(c[i*8 +: 8]);
          lat = 0;
        end
      end
      if (exp_valid && out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) acc.delete();
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send_elem(input logic [7:0] d, input int gap);
    bit got;
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!got) check("in_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_job(input logic [31:0] a, input logic [31:0] b, input bit gaps);
    for (int k = 0; k < NE; k++) send_elem(a[k*8 +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
    for (int k = 0; k < NE; k++) send_elem(b[k*8 +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      n++;
    end
    if (!ok) check("out_timeout", 32'd0, 32'd1);
  endtask

  task automatic recv_job(input string tag, input logic [31:0] exp_c,
                          input int stall_at, input int stall_len);
    bit ok;
    logic [7:0] hold;
    for (int k = 0; k < NE; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        wait_valid(ok);
        if (!ok) return;
        hold = out_data;
        for (int s = 0; s < stall_len; s++) begin
          if (s > 0) @(negedge clk);
          check({tag, "_stall_data"}, {24'd0, out_data}, {24'd0, hold});
          check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
          @(posedge clk); #1;
        end
        stall_total += stall_len;
        out_ready = 1'b1;
      end
      wait_valid(ok);
      if (!ok) return;
      check({tag, "_elem"}, {24'd0, out_data}, {24'd0, exp_c[k*8 +: 8]});
      check({tag, "_done"}, {31'd0, done}, {31'd0, k == NE-1});
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_in_ready_q", {31'd0, in_ready}, 32'd0);
    check("rst_mm_a", mm_a, 32'd0);
    check("rst_mm_b", mm_b, 32'd0);
    rst_n = 1'b1;
    stall_total = 0;
  endtask

  localparam logic [31:0] A_BASIC = 32'h04030201;
  localparam logic [31:0] B_BASIC = 32'h08070605;
  localparam logic [31:0] C_BASIC = 32'h322B1613;  // 19,22,43,50
  localparam logic [31:0] A_OVF   = 32'h0C0C0C0C;
  localparam logic [31:0] C_OVF   = 32'h20202020;  // 288 mod 256 = 32
  localparam logic [31:0] A_TWO   = 32'h02000002;  // 2*I
  localparam logic [31:0] C_TWO   = 32'h08060402;  // 2*A_BASIC

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lcnt;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    l3_in_valid = 1'b0; l3_in_data = '0; l3_out_ready = 1'b1;
    stall_total = 0;
    @(posedge clk); #1;
    apply_reset();

    // Latency: COMP_LAT=3, operands held through WAIT, first out_valid 4 cycles after last B beat.
    for (int k = 0; k < 2*NE; k++) begin
      l3_in_valid = 1'b1;
      l3_in_data  = (k < NE) ? A_BASIC[k*8 +: 8] : B_BASIC[(k-NE)*8 +: 8];
      @(negedge clk);
      check("l3_in_ready", {31'd0, l3_in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    l3_in_valid = 1'b0;
    lcnt = 1;
    while (lcnt < 20) begin
      @(negedge clk);
      if (l3_out_valid) break;
      check("l3_busy_wait", {31'd0, l3_busy}, 32'd1);
      check("l3_in_ready_wait", {31'd0, l3_in_ready}, 32'd0);
      check("l3_mm_a_wait", l3_mm_a, A_BASIC);
      check("l3_mm_b_wait", l3_mm_b, B_BASIC);
      @(posedge clk); #1;
      lcnt++;
    end
    check("l3_latency", lcnt, 32'd4);
    for (int k = 0; k < NE; k++) begin
      if (k > 0) @(negedge clk);
      check("l3_out_valid", {31'd0, l3_out_valid}, 32'd1);
      check("l3_out_data", {24'd0, l3_out_data}, {24'd0, C_BASIC[k*8 +: 8]});
      check("l3_done", {31'd0, l3_done}, {31'd0, k == NE-1});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("l3_out_valid_end", {31'd0, l3_out_valid}, 32'd0);
    check("l3_busy_end", {31'd0, l3_busy}, 32'd0);
    @(posedge clk); #1;

    // Basic 2x2.
    send_job(A_BASIC, B_BASIC, 1'b0);
    recv_job("basic", C_BASIC, -1, 0);
    check("basic_mm_a", mm_a, A_BASIC);
    check("basic_mm_b", mm_b, B_BASIC);

    // Overflow wrap.
    send_job(A_OVF, A_OVF, 1'b0);
    recv_job("ovf", C_OVF, -1, 0);

    // Backpressure: random input gaps, 5-cycle stall mid-drain.
    send_job(A_BASIC, B_BASIC, 1'b1);
    recv_job("bp", C_BASIC, 2, 5);

    // Reset after the 2nd B beat, then a fresh job.
    for (int k = 0; k < NE; k++) send_elem(A_OVF[k*8 +: 8], 0);
    send_elem(8'd9, 0);
    send_elem(8'd9, 1);
    apply_reset();
    send_job(A_TWO, A_BASIC, 1'b0);
    recv_job("rst", C_TWO, -1, 0);

    // Three back-to-back jobs from a clean reset.
    apply_reset();
    send_job(A_BASIC, B_BASIC, 1'b0);
    recv_job("b2b0", C_BASIC, 1, 2);
    send_job(A_OVF, A_OVF, 1'b0);
    recv_job("b2b1", C_OVF, -1, 0);
    send_job(A_TWO, A_BASIC, 1'b1);
    recv_job("b2b2", C_TWO, 3, 3);
`ifdef MATMUL_SEQ_CTRL_PERF_EN
    @(negedge clk);
    check("job_cnt", {16'd0, job_cnt}, 32'd3);
    check("stall_cnt", {16'd0, stall_cnt}, stall_total);
    check("stall_cnt_lit", {16'd0, stall_cnt}, 32'd5);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequencing controller for the combinational N×N matrix multiplier.
- Accepts A and B as a byte-wide valid/ready element stream and assembles them into flat packed operand buses.
- Drives those buses to the external multiplier instance, waits a fixed settle latency, then captures the packed result.
- Streams the result back out one element per handshake.
- Sits between the host/DMA stream interface and the multiplier datapath.

Parameters:
- N, 2, matrix dimension (N×N operands and result).
- DW, 8, element width in bits; the multiplier's packed buses are N*N*DW wide.
- COMP_LAT, 1, cycles to wait between operand hold and result capture (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts an input element.
- in_data  in  DW  input element; A elements first, then B, each in row-major order.
- mm_a  out  N*N*DW  packed A to the multiplier; element i*N+j at bits [(i*N+j)*DW +: DW].
- mm_b  out  N*N*DW  packed B to the multiplier, same packing.
- mm_res  in  N*N*DW  packed product from the multiplier, same packing.
- out_valid  out  1  result element valid.
- out_ready  in  1  downstream accepts a result element.
- out_data  out  DW  result element, row-major order.
- busy  out  1  high in the WAIT and DRAIN states.
- done  out  1  one-cycle pulse on acceptance of the last result element.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=LOAD_A, idx=0, wait counter=0.
  - mm_a=0, mm_b=0, result register=0.
  - out_valid=0, out_data=0, busy=0, done=0.
  - in_ready is forced 0 while rst_n=0.
- States: LOAD_A, LOAD_B, WAIT, DRAIN.
  - idx counts 0..N*N-1.
  - wcnt counts 0..COMP_LAT-1.
- LOAD_A:
  - in_ready=1.
  - On in_valid&&in_ready: mm_a[idx*DW +: DW] <= in_data; idx++.
  - On the beat with idx==N*N-1: idx<=0, go to LOAD_B.
- LOAD_B:
  - Same as LOAD_A but writes mm_b.
  - On the last beat: go to WAIT, wcnt<=0.
- WAIT:
  - in_ready=0; mm_a and mm_b are held stable.
  - wcnt increments each cycle.
  - When wcnt==COMP_LAT-1: result register <= mm_res, go to DRAIN, idx<=0.
  - Latency from the last B beat to the first out_valid is COMP_LAT+1 cycles.
- DRAIN:
  - out_valid=1; out_data = result[idx*DW +: DW], registered, and stable while out_ready=0.
  - On out_valid&&out_ready: idx++.
  - On the last element: done=1 for one cycle, out_valid deasserts the next cycle, go to LOAD_A.
  - A new job is not accepted until the drain completes; there is no load/drain overlap.
- Arithmetic: performed entirely in the external multiplier. Each result element is the low DW bits of its sum of products (modulo 2^DW). The controller neither widens nor saturates.
- in_valid is ignored outside the LOAD states. out_ready is ignored outside DRAIN.
- Any rst_n=0 mid-job, in any state, discards partial operands and results and returns to LOAD_A with idx=0.
- Stalls: in_valid=0 or out_ready=0 for any number of cycles freezes idx and state. No timeout.

Optional Feature:
Macro MATMUL_SEQ_CTRL_PERF_EN.
- When defined:
  - Adds output port job_cnt [15:0], incremented on each done pulse, wrapping at 0xFFFF→0.
  - Adds output port stall_cnt [15:0], counting DRAIN cycles with out_ready=0; saturates at 0xFFFF.
  - Both counters reset to 0.
- When undefined: neither port nor its logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared package matmul_pkg holds:
  - the state encoding localparams (LOAD_A=0, LOAD_B=1, WAIT=2, DRAIN=3);
  - the default DW=8 and N=2;
  - a packed-index helper function (i*N+j)*DW.
- No sub-module needed. The multiplier stays an external instance wired at the parent level, so the controller can be verified against a behavioural model.

Test Plan:
- Basic 2×2, COMP_LAT=1: stream 1,2,3,4 then 5,6,7,8 → outputs 19,22,43,50 in order, then done pulse; mm_a=={8'd4,8'd3,8'd2,8'd1}.
- Overflow wrap: A all 12, B all 12 → every output 32 (288 mod 256).
- Backpressure/gaps:
  - random in_valid gaps and out_ready=0 for 5 cycles mid-drain;
  - required: out_data stable while stalled, no element lost or duplicated, and the result equals the basic case.
- Latency: COMP_LAT=3 → first out_valid exactly 4 cycles after the last B beat; mm_a/mm_b unchanged throughout WAIT.
- Reset mid-job:
  - drive rst_n=0 for one cycle after the 2nd B beat, then stream a fresh full job;
  - required: all outputs zeroed during reset, and the result reflects only the new job.
- Back-to-back jobs, with PERF_EN defined:
  - run three jobs; required: job_cnt==3;
  - stall_cnt equals the number of injected out_ready=0 DRAIN cycles.
